// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state/owner encodings and counter widths for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

    // Streak holds up to 15, watchdog up to 255.
    localparam int STREAK_W = 4;
    localparam int WD_W     = 8;

endpackage

// File: rtl/arb_sat_counter.sv
// rtl/arb_sat_counter.sv - up counter with clear that saturates at LIMIT
module arb_sat_counter #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [WIDTH-1:0] count;

    assign sat = (count == WIDTH'(LIMIT));

    // Clear wins over increment; increments stop once the limit is held.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between fetch and load/store ports
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    output logic        bus_err
);

    arb_state_t  state;
    arb_state_t  state_nxt;
    arb_owner_t  owner;
    logic        grant_d;
    logic        grant_if;
    logic        load_resp;
    logic        abort;
    logic        streak_sat;
    logic        wd_sat;
    logic        wd_hit;
    logic        rvalid_q;
    logic        bus_err_q;
    logic [31:0] rdata_q;

    // Watchdog saturates one short of the timeout so that sat marks the last allowed busy cycle.
    assign wd_hit = (state != ARB_IDLE) && wd_sat;

    arb_sat_counter #(
        .WIDTH (STREAK_W),
        .LIMIT (MAX_D_STREAK)
    ) u_streak (
        .clk (clk),
        .rst (rst),
        .inc (grant_d && if_req),
        .clr ((state == ARB_IDLE) && (grant_if || !if_req)),
        .sat (streak_sat)
    );

    arb_sat_counter #(
        .WIDTH (WD_W),
        .LIMIT (TIMEOUT_CYC - 1)
    ) u_watchdog (
        .clk (clk),
        .rst (rst),
        .inc (state != ARB_IDLE),
        .clr (state == ARB_IDLE),
        .sat (wd_sat)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration, memory handshake and completion decode.
    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_if  = 1'b0;
        m_valid   = 1'b0;
        load_resp = 1'b0;
        abort     = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (!rst) begin
                    if (d_req && !(if_req && streak_sat)) begin
                        grant_d = 1'b1;
                    end else if (if_req) begin
                        grant_if = 1'b1;
                    end
                end
                if (grant_d || grant_if) begin
                    state_nxt = ARB_REQ;
                end
            end
            ARB_REQ: begin
                // m_valid is withdrawn in the abort cycle so memory cannot accept a dead request.
                if (wd_hit) begin
                    abort     = 1'b1;
                    state_nxt = ARB_IDLE;
                end else begin
                    m_valid = 1'b1;
                    if (m_ready) begin
                        state_nxt = ARB_WAIT;
                    end
                end
            end
            ARB_WAIT: begin
                if (m_rvalid) begin
                    load_resp = 1'b1;
                    state_nxt = ARB_IDLE;
                end else if (wd_hit) begin
                    abort     = 1'b1;
                    state_nxt = ARB_IDLE;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    // Request capture on grant and response registration on completion or abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= OWN_IF;
            m_we      <= 1'b0;
            m_be      <= 4'h0;
            m_addr    <= 32'h0;
            m_wdata   <= 32'h0;
            rdata_q   <= 32'h0;
            rvalid_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            rvalid_q  <= load_resp || abort;
            bus_err_q <= abort;
            if (load_resp) begin
                rdata_q <= m_we ? 32'h0 : m_rdata;
            end else if (abort) begin
                rdata_q <= 32'h0;
            end
            if (grant_d) begin
                owner   <= OWN_D;
                m_we    <= d_we;
                m_be    <= d_be;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
            end else if (grant_if) begin
                owner   <= OWN_IF;
                m_we    <= 1'b0;
                m_be    <= 4'hF;
                m_addr  <= if_addr;
                m_wdata <= 32'h0;
            end
        end
    end

    assign if_gnt    = grant_if;
    assign d_gnt     = grant_d;
    assign if_rvalid = rvalid_q && (owner == OWN_IF);
    assign d_rvalid  = rvalid_q && (owner == OWN_D);
    assign if_rdata  = if_rvalid ? rdata_q : 32'h0;
    assign d_rdata   = d_rvalid ? rdata_q : 32'h0;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with memory and requester models
module tb_mem_port_arbiter;

    localparam int MAX_D = 4;
    localparam int TO    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_valid;
    logic        m_ready;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        bus_err;

    mem_port_arbiter #(.MAX_D_STREAK(MAX_D), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .bus_err(bus_err)
    );

    typedef struct packed { logic [31:0] data; logic err; } resp_t;
    typedef struct packed { logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; } mreq_t;

    resp_t       if_exp_q[$];
    resp_t       d_exp_q[$];
    mreq_t       req_exp_q[$];
    logic [31:0] ref_mem  [0:1023];
    logic [31:0] phys_mem [0:1023];

    int    checks = 0;
    int    fails = 0;
    int    cyc = 0;
    int    force_rw = -1;
    int    force_rv = -1;
    int    late_rv = 0;
    bit    hang = 1'b0;
    bit    never_ready = 1'b0;
    int    mem_accepts = 0;
    int    last_valid_len = 0;
    int    if_wait_d = 0;
    bit    prev_mvalid = 1'b0;
    int    last_mvalid_rise = 0;
    int    last_if_gnt = 0;
    int    last_if_rvalid = 0;
    int    last_bus_err = 0;
    string glog = "";

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input bit act, input bit exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Requester models: expected response goes into the scoreboard at issue time.
    task automatic fetch_issue(input logic [31:0] addr, input bit exp_err);
        resp_t r;
        bit got = 1'b0;
        r.data = exp_err ? 32'h0 : ref_mem[addr[11:2]];
        r.err  = exp_err;
        if_exp_q.push_back(r);
        @(posedge clk); #1;
        if_addr = addr;
        if_req  = 1'b1;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            got = if_gnt;
        end
        check1("if_gnt_wait", got, 1'b1);
        @(posedge clk); #1;
        if_req  = 1'b0;
        if_addr = $urandom;
    endtask

    task automatic data_issue(input bit we, input logic [3:0] be, input logic [31:0] addr,
                              input logic [31:0] wdata, input bit exp_err);
        resp_t r;
        bit got = 1'b0;
        r.err = exp_err;
        if (exp_err) begin
            r.data = 32'h0;
        end else if (we) begin
            r.data = 32'h0;
            ref_mem[addr[11:2]] = merge(ref_mem[addr[11:2]], wdata, be);
        end else begin
            r.data = ref_mem[addr[11:2]];
        end
        d_exp_q.push_back(r);
        @(posedge clk); #1;
        d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
        d_req = 1'b1;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            got = d_gnt;
        end
        check1("d_gnt_wait", got, 1'b1);
        @(posedge clk); #1;
        d_req = 1'b0;
        d_addr = $urandom;
        d_wdata = $urandom;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            done = (if_exp_q.size() == 0) && (d_exp_q.size() == 0) && !m_valid && !if_req && !d_req;
        end
        check1({name, "_drain"}, done, 1'b1);
    endtask

    // Memory model: accepts after a chosen number of wait cycles, answers from its own array.
    initial begin
        mreq_t       e;
        int          nvalid;
        int          rw;
        int          rv;
        logic [31:0] a;
        logic        we;
        m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (rst || !m_valid) continue;
            check1("m_valid_expected", req_exp_q.size() != 0, 1'b1);
            if (req_exp_q.size() == 0) continue;
            e = req_exp_q.pop_front();
            check32("m_addr", m_addr, e.addr);
            check1("m_we", m_we, e.we);
            if (e.we) begin
                check32("m_be", {28'h0, m_be}, {28'h0, e.be});
                check32("m_wdata", m_wdata, e.wdata);
            end
            if (never_ready) begin
                for (int k = 0; k < 300 && m_valid; k++) @(negedge clk);
                continue;
            end
            rw = (force_rw >= 0) ? force_rw : int'($urandom_range(0, 2));
            nvalid = 1;
            for (int k = 0; k < rw; k++) begin
                @(negedge clk);
                if (!m_valid) break;
                nvalid++;
                check32("m_addr_stable", m_addr, e.addr);
                check32("m_wdata_stable", m_wdata, e.wdata);
            end
            if (!m_valid) continue;
            a  = m_addr;
            we = m_we;
            if (we) phys_mem[a[11:2]] = merge(phys_mem[a[11:2]], m_wdata, m_be);
            m_ready = 1'b1;
            mem_accepts++;
            last_valid_len = nvalid;
            @(negedge clk);
            m_ready = 1'b0;
            if (hang) continue;
            rv = (late_rv > 0) ? late_rv : ((force_rv >= 0) ? force_rv : int'($urandom_range(0, 2)));
            repeat (rv) @(negedge clk);
            m_rvalid = 1'b1;
            m_rdata  = we ? 32'hBAD0BAD0 : phys_mem[a[11:2]];
            @(negedge clk);
            m_rvalid = 1'b0;
            m_rdata  = 32'h0;
        end
    end

    // Monitor: grant rules, request capture and response scoreboard.
    always @(negedge clk) begin
        resp_t r;
        mreq_t q;
        if (rst) begin
            if_exp_q.delete();
            d_exp_q.delete();
            req_exp_q.delete();
            if_wait_d = 0;
            prev_mvalid = 1'b0;
        end else begin
            if (m_valid && !prev_mvalid) last_mvalid_rise = cyc;
            prev_mvalid = m_valid;
            if (if_gnt || d_gnt) begin
                check1("single_gnt", if_gnt && d_gnt, 1'b0);
                if (d_gnt && !if_gnt) begin
                    check1("d_gnt_requested", d_req, 1'b1);
                    if (if_req) begin
                        check1("fetch_starve", if_wait_d < MAX_D, 1'b1);
                        if_wait_d++;
                    end else begin
                        if_wait_d = 0;
                    end
                    q.we = d_we; q.be = d_be; q.addr = d_addr; q.wdata = d_wdata;
                    req_exp_q.push_back(q);
                    glog = {glog, "D"};
                end else if (if_gnt && !d_gnt) begin
                    check1("if_gnt_requested", if_req, 1'b1);
                    check1("data_priority", !d_req || (if_wait_d == MAX_D), 1'b1);
                    if_wait_d = 0;
                    q.we = 1'b0; q.be = 4'hF; q.addr = if_addr; q.wdata = 32'h0;
                    req_exp_q.push_back(q);
                    glog = {glog, "I"};
                    last_if_gnt = cyc;
                end
            end
            if (if_rvalid || d_rvalid) begin
                check1("single_rvalid", if_rvalid && d_rvalid, 1'b0);
                if (if_rvalid) begin
                    check1("if_rvalid_expected", if_exp_q.size() != 0, 1'b1);
                    if (if_exp_q.size() != 0) begin
                        r = if_exp_q.pop_front();
                        check32("if_rdata", if_rdata, r.data);
                        check1("if_bus_err", bus_err, r.err);
                    end
                    last_if_rvalid = cyc;
                end
                if (d_rvalid) begin
                    check1("d_rvalid_expected", d_exp_q.size() != 0, 1'b1);
                    if (d_exp_q.size() != 0) begin
                        r = d_exp_q.pop_front();
                        check32("d_rdata", d_rdata, r.data);
                        check1("d_bus_err", bus_err, r.err);
                    end
                end
            end
            if (bus_err) begin
                check1("bus_err_with_rvalid", if_rvalid || d_rvalid, 1'b1);
                last_bus_err = cyc;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int start_acc;
        int pulses;
        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
        d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i]  = (i * 32'h01000193) ^ 32'h5A5A0000;
            phys_mem[i] = (i * 32'h01000193) ^ 32'h5A5A0000;
        end
        ref_mem[64]  = 32'h00500093;
        phys_mem[64] = 32'h00500093;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("reset_outputs_zero",
               {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, m_valid, m_we, m_be,
                m_addr, m_wdata, bus_err} == '0, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single fetch at minimum latency.
        force_rw = 0; force_rv = 0;
        fetch_issue(32'h100, 1'b0);
        wait_idle("t1");
        check32("t1_mvalid_latency", last_mvalid_rise - last_if_gnt, 32'd1);
        check32("t1_rvalid_latency", last_if_rvalid - last_if_gnt, 32'd3);

        // Simultaneous fetch and load: data first.
        force_rw = -1; force_rv = -1;
        glog = "";
        fork
            data_issue(1'b0, 4'hF, 32'h2000, 32'h0, 1'b0);
            fetch_issue(32'h100, 1'b0);
        join
        wait_idle("t2");
        check1("t2_order", glog == "DI", 1'b1);

        // Streak limit forces a fetch after MAX_D data grants.
        glog = "";
        fork
            begin
                for (int i = 0; i < 8; i++)
                    data_issue(1'b0, 4'hF, 32'h2000 + 32'(i * 4), 32'h0, 1'b0);
            end
            begin
                fetch_issue(32'h104, 1'b0);
                fetch_issue(32'h108, 1'b0);
            end
        join
        wait_idle("t3");
        check1("t3_order", glog == "DDDDIDDDDI", 1'b1);
        if (glog != "DDDDIDDDDI") $display("t3 grant log %s", glog);

        // Byte-masked store with a slow accept, then read it back.
        force_rw = 3; force_rv = 0;
        data_issue(1'b1, 4'b0011, 32'h2000, 32'hDEADBEEF, 1'b0);
        wait_idle("t4");
        check32("t4_valid_len", last_valid_len, 32'd4);
        force_rw = -1; force_rv = -1;
        data_issue(1'b0, 4'hF, 32'h2000, 32'h0, 1'b0);
        wait_idle("t4_load");

        // Watchdog: no response in WAIT, then no accept in REQ.
        hang = 1'b1;
        fetch_issue(32'h180, 1'b1);
        wait_idle("t5a");
        check32("t5a_timeout_latency", last_bus_err - last_mvalid_rise, 32'(TO));
        hang = 1'b0;
        never_ready = 1'b1;
        data_issue(1'b0, 4'hF, 32'h2010, 32'h0, 1'b1);
        wait_idle("t5b");
        check32("t5b_timeout_latency", last_bus_err - last_mvalid_rise, 32'(TO));
        never_ready = 1'b0;
        fetch_issue(32'h184, 1'b0);
        wait_idle("t5c");

        // Reset while waiting on memory; the late response must be ignored.
        force_rw = 0; late_rv = 3;
        start_acc = mem_accepts;
        fetch_issue(32'h140, 1'b0);
        for (int k = 0; k < 50 && mem_accepts == start_acc; k++) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check1("t6_outputs_zero",
               {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, m_valid, m_we, m_be,
                m_addr, m_wdata, bus_err} == '0, 1'b1);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (if_rvalid || d_rvalid) pulses++;
        end
        check32("t6_no_rvalid", pulses, 32'd0);
        late_rv = 0; force_rw = -1;
        fetch_issue(32'h104, 1'b0);
        wait_idle("t6");

        // Randomised concurrent traffic.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    fetch_issue(32'h100 + 32'($urandom_range(0, 63)) * 32'd4, 1'b0);
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    data_issue(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                               32'h2000 + 32'($urandom_range(0, 15)) * 32'd4, $urandom, 1'b0);
                end
            end
        join
        wait_idle("random");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
